// File: rtl/snail_ctrl.sv
// rtl/snail_ctrl.sv - frame shifter feeding a SAD/HOPE/HOORAY run detector.
// Counts detector entries into HOORAY over each WIDTH-bit frame, MSB first.
module snail_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             start,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNTW-1:0]  count
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SAD, HOPE, HOORAY} det_t;

  state_t           state_q, state_d;
  det_t             det_q, det_d, det_step;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNTW-1:0]  count_q, count_d;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= IDLE;
      det_q   <= SAD;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Detector step for the bit currently at the head of the shift register.
  always_comb begin
    det_step = SAD;
    if (shreg_q[WIDTH-1]) begin
      case (det_q)
        SAD:     det_step = HOPE;
        HOPE:    det_step = HOORAY;
        HOORAY:  det_step = HOPE;
        default: det_step = HOPE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (clr) begin
      state_d = IDLE;
      det_d   = SAD;
      idx_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = SHIFT;
            det_d   = SAD;
            shreg_d = data;
            idx_d   = '0;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          det_d   = det_step;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          idx_d   = idx_q + IW'(1);
          if (det_step == HOORAY && count_q != {CNTW{1'b1}}) begin
            count_d = count_q + CNTW'(1);
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign hit   = (state_q == SHIFT) && (det_q == HOORAY);
  assign count = count_q;

endmodule
